// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port 16-bit word RAM.
// Round-robin or fixed-priority grant, byte-lane writes, lock for atomic sequences.
//
// state    | meaning
// OWN_NONE | no lock held; normal arbitration between both ports
// OWN_P0   | port 0 holds the lock; port 1 requests are ignored
// OWN_P1   | port 1 holds the lock; port 0 requests are ignored
module mem_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [1:0]        i_be0,
  input  logic [1:0]        i_be1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_lock0,
  input  logic              i_lock1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [1:0]        o_ram_be,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   r_last;
  logic   r_resp_pending;
  logic   r_resp_port;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_en;
  logic   w_we_sel;
  logic   w_read_gnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner        <= OWN_NONE;
      r_last         <= 1'b1;
      r_resp_pending <= 1'b0;
      r_resp_port    <= 1'b0;
    end else begin
      r_owner        <= w_owner_nxt;
      r_resp_pending <= w_read_gnt;
      if (w_en) begin
        r_last      <= w_gnt1;
        r_resp_port <= w_gnt1;
      end
    end
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = r_owner;
    case (r_owner)
      OWN_P0: begin
        w_gnt0 = i_req0;
        if (i_req0 || !i_lock0) begin
          w_owner_nxt = (i_req0 && i_lock0) ? OWN_P0 : OWN_NONE;
        end
      end
      OWN_P1: begin
        w_gnt1 = i_req1;
        if (i_req1 || !i_lock1) begin
          w_owner_nxt = (i_req1 && i_lock1) ? OWN_P1 : OWN_NONE;
        end
      end
      default: begin
        if (i_req0 && i_req1) begin
          // r_last = 1 means port 1 was granted most recently
          if (FIXED_PRIO != 0 || r_last) w_gnt0 = 1'b1;
          else                           w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = i_req0;
          w_gnt1 = i_req1;
        end
        if (w_gnt0 && i_lock0)      w_owner_nxt = OWN_P0;
        else if (w_gnt1 && i_lock1) w_owner_nxt = OWN_P1;
      end
    endcase
    // Reset blocks any access issue combinationally, not just at the next edge.
    if (!i_rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_en       = w_gnt0 | w_gnt1;
  assign w_we_sel   = w_gnt1 ? i_we1 : i_we0;
  assign w_read_gnt = w_en & ~w_we_sel;

  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_ram_en    = w_en;
  assign o_ram_we    = w_en & w_we_sel;
  assign o_ram_be    = o_ram_we ? (w_gnt1 ? i_be1 : i_be0) : 2'b00;
  assign o_ram_addr  = w_gnt1 ? i_addr1 : i_addr0;
  assign o_ram_wdata = w_gnt1 ? i_wdata1 : i_wdata0;

  assign o_rvalid0 = r_resp_pending & ~r_resp_port;
  assign o_rvalid1 = r_resp_pending & r_resp_port;
  assign o_rdata   = i_ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a behavioural model checks both every cycle, directed sequences pin literal values.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic ram_init;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [4:0]  addr0, addr1;
  logic [1:0]  be0, be1;
  logic [15:0] wdata0, wdata1;

  logic        gnt0 [2];
  logic        gnt1 [2];
  logic        rvalid0 [2];
  logic        rvalid1 [2];
  logic        ram_en [2];
  logic        ram_we [2];
  logic [1:0]  ram_be [2];
  logic [4:0]  ram_addr [2];
  logic [15:0] rdata [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];
  logic [15:0] bram [2][32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(16), .FIXED_PRIO(0)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_addr0(addr0), .i_addr1(addr1),
    .i_we0(we0), .i_we1(we1), .i_be0(be0), .i_be1(be1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .i_lock0(lock0), .i_lock1(lock1),
    .o_gnt0(gnt0[0]), .o_gnt1(gnt1[0]), .o_rvalid0(rvalid0[0]), .o_rvalid1(rvalid1[0]),
    .o_rdata(rdata[0]), .o_ram_en(ram_en[0]), .o_ram_we(ram_we[0]), .o_ram_be(ram_be[0]),
    .o_ram_addr(ram_addr[0]), .o_ram_wdata(ram_wdata[0]), .i_ram_rdata(ram_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(5), .DATA_W(16), .FIXED_PRIO(1)) u_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_addr0(addr0), .i_addr1(addr1),
    .i_we0(we0), .i_we1(we1), .i_be0(be0), .i_be1(be1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .i_lock0(lock0), .i_lock1(lock1),
    .o_gnt0(gnt0[1]), .o_gnt1(gnt1[1]), .o_rvalid0(rvalid0[1]), .o_rvalid1(rvalid1[1]),
    .o_rdata(rdata[1]), .o_ram_en(ram_en[1]), .o_ram_we(ram_we[1]), .o_ram_be(ram_be[1]),
    .o_ram_addr(ram_addr[1]), .o_ram_wdata(ram_wdata[1]), .i_ram_rdata(ram_rdata[1])
  );

  function automatic logic [15:0] init_val(int i);
    if (i == 3) return 16'hA55A;
    if (i == 7) return 16'h1234;
    return 16'hC000 | (16'(i) << 8) | 16'(i);
  endfunction

  // Single-port RAM per instance, registered read.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 32; i++) bram[g][i] <= init_val(i);
      end else if (ram_en[g]) begin
        if (ram_we[g]) begin
          if (ram_be[g][0]) bram[g][ram_addr[g]][7:0]  <= ram_wdata[g][7:0];
          if (ram_be[g][1]) bram[g][ram_addr[g]][15:8] <= ram_wdata[g][15:8];
        end else begin
          ram_rdata[g] <= bram[g][ram_addr[g]];
        end
      end
    end
  end

  task automatic chk(int k, string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", k, name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_owner [2];
  int          m_last [2];
  int          m_pend [2];
  logic [15:0] m_pdata [2];
  logic [15:0] m_mem [2][32];

  function automatic int arb(int k, int owner, int last);
    if (!rst_n) return -1;
    if (owner == 0) return req0 ? 0 : -1;
    if (owner == 1) return req1 ? 1 : -1;
    if (req0 && req1) return (k == 1) ? 0 : (last == 0 ? 1 : 0);
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_mem[k][i] = init_val(i);
      m_owner[k] = -1;
      m_last[k]  = 1;
      m_pend[k]  = -1;
      m_pdata[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int          eg;
        logic        e_we, e_lock, o_req, o_lock;
        logic [4:0]  e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_wd;
        if (!rst_n) begin
          m_owner[k] = -1;
          m_last[k]  = 1;
          m_pend[k]  = -1;
        end
        eg = arb(k, m_owner[k], m_last[k]);
        chk(k, "gnt0", gnt0[k], eg == 0);
        chk(k, "gnt1", gnt1[k], eg == 1);
        chk(k, "ram_en", ram_en[k], eg >= 0);
        e_we   = (eg == 1) ? we1 : we0;
        e_addr = (eg == 1) ? addr1 : addr0;
        e_be   = (eg == 1) ? be1 : be0;
        e_wd   = (eg == 1) ? wdata1 : wdata0;
        e_lock = (eg == 1) ? lock1 : lock0;
        if (eg >= 0) begin
          chk(k, "ram_we", ram_we[k], e_we);
          chk(k, "ram_addr", ram_addr[k], e_addr);
          chk(k, "ram_be", ram_be[k], e_we ? e_be : 2'b00);
          if (e_we) chk(k, "ram_wdata", ram_wdata[k], e_wd);
        end else begin
          chk(k, "ram_we_idle", ram_we[k], 1'b0);
        end
        chk(k, "rvalid0", rvalid0[k], m_pend[k] == 0);
        chk(k, "rvalid1", rvalid1[k], m_pend[k] == 1);
        if (m_pend[k] >= 0) chk(k, "rdata", rdata[k], m_pdata[k]);

        // advance the model to the next cycle
        m_pend[k] = -1;
        if (eg >= 0) begin
          m_last[k] = eg;
          if (e_we) begin
            if (e_be[0]) m_mem[k][e_addr][7:0]  = e_wd[7:0];
            if (e_be[1]) m_mem[k][e_addr][15:8] = e_wd[15:8];
          end else begin
            m_pend[k]  = eg;
            m_pdata[k] = m_mem[k][e_addr];
          end
        end
        if (m_owner[k] >= 0) begin
          o_req  = (m_owner[k] == 1) ? req1 : req0;
          o_lock = (m_owner[k] == 1) ? lock1 : lock0;
          if (eg == m_owner[k]) begin
            if (!e_lock) m_owner[k] = -1;
          end else if (!o_req && !o_lock) begin
            m_owner[k] = -1;
          end
        end else if (eg >= 0 && e_lock) begin
          m_owner[k] = eg;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(int p);
    if (p == 0) begin
      req0   = ($urandom_range(0, 2) != 0);
      addr0  = 5'($urandom_range(0, 31));
      we0    = 1'($urandom_range(0, 1));
      be0    = 2'($urandom_range(0, 3));
      wdata0 = 16'($urandom);
      lock0  = ($urandom_range(0, 3) == 0);
    end else begin
      req1   = ($urandom_range(0, 2) != 0);
      addr1  = 5'($urandom_range(0, 31));
      we1    = 1'($urandom_range(0, 1));
      be1    = 2'($urandom_range(0, 3));
      wdata1 = 16'($urandom);
      lock1  = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    logic g0, g1;
    rst_n = 1'b0; ram_init = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; be0 = '0; be1 = '0; wdata0 = '0; wdata1 = '0;
    step();
    ram_init = 1'b0;

    // reset held: a request must not be granted
    req0 = 1; addr0 = 5'd0;
    @(negedge clk);
    chk(0, "rst_gnt0", gnt0[0], 1'b0);
    chk(0, "rst_ram_en", ram_en[0], 1'b0);
    chk(0, "rst_rvalid0", rvalid0[0], 1'b0);
    chk(0, "rst_rvalid1", rvalid1[0], 1'b0);

    // release with both reading: port 0 first
    step();
    rst_n = 1; addr0 = 5'd3; req1 = 1; addr1 = 5'd5;
    @(negedge clk);
    chk(0, "first_gnt0", gnt0[0], 1'b1);
    chk(0, "first_gnt1", gnt1[0], 1'b0);
    chk(0, "first_addr", ram_addr[0], 5'd3);
    step();
    req0 = 0;
    @(negedge clk);
    chk(0, "rd_rvalid0", rvalid0[0], 1'b1);
    chk(0, "rd_rdata", rdata[0], 16'hA55A);
    chk(0, "rd_rvalid1", rvalid1[0], 1'b0);
    chk(0, "p1_gnt1", gnt1[0], 1'b1);
    step();
    req1 = 0;
    @(negedge clk);
    chk(0, "p1_rvalid1", rvalid1[0], 1'b1);
    chk(0, "p1_rdata", rdata[0], 16'hC505);

    // contention: RR alternates, fixed priority always port 0
    step();
    req0 = 1; addr0 = 5'd4; req1 = 1; addr1 = 5'd6;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(0, "rr_gnt0", gnt0[0], (i % 2) == 0);
      chk(0, "rr_gnt1", gnt1[0], (i % 2) == 1);
      chk(0, "rr_rvalid0", rvalid0[0], (i % 2) == 1);
      chk(0, "rr_rvalid1", rvalid1[0], i > 0 && (i % 2) == 0);
      if (i < 4) begin
        chk(1, "fp_gnt0", gnt0[1], 1'b1);
        chk(1, "fp_gnt1", gnt1[1], 1'b0);
      end
      step();
    end
    req0 = 0;
    @(negedge clk);
    chk(1, "fp_gnt1_drop", gnt1[1], 1'b1);
    chk(0, "rr_gnt1_drop", gnt1[0], 1'b1);

    // byte write then readback
    step();
    we1 = 1; addr1 = 5'd7; be1 = 2'b10; wdata1 = 16'h3C00;
    @(negedge clk);
    chk(0, "bw_gnt1", gnt1[0], 1'b1);
    chk(0, "bw_ram_we", ram_we[0], 1'b1);
    chk(0, "bw_ram_be", ram_be[0], 2'b10);
    step();
    we1 = 0;
    @(negedge clk);
    chk(0, "bw_no_rvalid1", rvalid1[0], 1'b0);
    chk(0, "bw_no_rvalid0", rvalid0[0], 1'b0);
    step();
    req1 = 0;
    @(negedge clk);
    chk(0, "bw_rb_rvalid1", rvalid1[0], 1'b1);
    chk(0, "bw_rb_rdata", rdata[0], 16'h3C34);

    // locked read-modify-write on port 0 while port 1 waits
    step();
    req0 = 1; we0 = 0; addr0 = 5'd2; lock0 = 1;
    req1 = 1; we1 = 0; addr1 = 5'd9; lock1 = 0;
    @(negedge clk);
    chk(0, "lk_rd_gnt0", gnt0[0], 1'b1);
    chk(0, "lk_rd_gnt1", gnt1[0], 1'b0);
    step();
    we0 = 1; be0 = 2'b11; wdata0 = 16'hBEEF; lock0 = 0;
    @(negedge clk);
    chk(0, "lk_wr_gnt0", gnt0[0], 1'b1);
    chk(0, "lk_wr_gnt1", gnt1[0], 1'b0);
    chk(0, "lk_rd_rdata", rdata[0], 16'hC202);
    step();
    req0 = 0;
    @(negedge clk);
    chk(0, "lk_after_gnt1", gnt1[0], 1'b1);
    step();
    req1 = 0;

    // reset in the middle of a lock
    req0 = 1; we0 = 0; addr0 = 5'd2; lock0 = 1;
    @(negedge clk);
    chk(0, "mr_gnt0", gnt0[0], 1'b1);
    step();
    rst_n = 0; req1 = 1;
    @(negedge clk);
    chk(0, "mr_rvalid0", rvalid0[0], 1'b0);
    chk(0, "mr_gnt0_rst", gnt0[0], 1'b0);
    step();
    rst_n = 1; req0 = 0; lock0 = 0;
    @(negedge clk);
    chk(0, "mr_gnt1", gnt1[0], 1'b1);
    chk(0, "mr_rvalid0_after", rvalid0[0], 1'b0);
    step();
    req1 = 0;

    // randomized traffic, requester protocol follows the round-robin instance
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = gnt0[0];
      g1 = gnt1[0];
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      if (!req0 || g0 || $urandom_range(0, 15) == 0) new_req(0);
      if (!req1 || g1 || $urandom_range(0, 15) == 0) new_req(1);
    end
    step();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
